// File: rtl/bp_pkg.sv
// Shared constants and helpers for the branch-prediction table: default
// parameters and the saturating-counter reset value and limits.
package bp_pkg;
    localparam int CTR_W_DEF  = 2;
    localparam int IDX_W_DEF  = 4;
    localparam int HIST_W_DEF = 0;
    localparam int PC_W_DEF   = 32;

    // Widest counter supported; helpers return this width and callers truncate.
    localparam int CTR_W_MAX  = 4;

    localparam int          MIS_W   = 16;
    localparam logic [15:0] MIS_SAT = 16'hFFFF;

    // Weakly not-taken: one below the taken threshold.
    function automatic logic [CTR_W_MAX-1:0] ctr_rst_val(input int w);
        return CTR_W_MAX'((1 << (w - 1)) - 1);
    endfunction

    function automatic logic [CTR_W_MAX-1:0] ctr_max(input int w);
        return CTR_W_MAX'((1 << w) - 1);
    endfunction

    function automatic logic [CTR_W_MAX-1:0] ctr_min(input int w);
        return CTR_W_MAX'(w - w);
    endfunction
endpackage

// File: rtl/bp_table_if.sv
// Lookup/update bundle of the branch-prediction table; master is the core
// front end issuing lookups and resolutions, slave is the table.
interface bp_table_if
    import bp_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int HIST_W = HIST_W_DEF
);
    logic                                pred_valid;
    logic [PC_W-1:0]                     pred_pc;
    logic                                pred_rdy;
    logic                                pred_taken;
    logic [IDX_W-1:0]                    pred_idx;
    logic                                upd_valid;
    logic [IDX_W-1:0]                    upd_idx;
    logic                                upd_taken;
    logic                                upd_pred;
    logic [MIS_W-1:0]                    mispredict_cnt;
    logic [((HIST_W > 0) ? HIST_W : 1)-1:0] ghr;

    modport master (
        output pred_valid, pred_pc, upd_valid, upd_idx, upd_taken, upd_pred,
        input  pred_rdy, pred_taken, pred_idx, mispredict_cnt, ghr
    );

    modport slave (
        input  pred_valid, pred_pc, upd_valid, upd_idx, upd_taken, upd_pred,
        output pred_rdy, pred_taken, pred_idx, mispredict_cnt, ghr
    );
endinterface

// File: rtl/bp_sat_ctr.sv
// Next-state logic for one saturating direction counter.
module bp_sat_ctr
    import bp_pkg::*;
#(
    parameter int CTR_W = CTR_W_DEF
) (
    input  logic [CTR_W-1:0] cur,
    input  logic             taken,
    output logic [CTR_W-1:0] nxt
);
    localparam logic [CTR_W-1:0] C_MAX = CTR_W'(ctr_max(CTR_W));
    localparam logic [CTR_W-1:0] C_MIN = CTR_W'(ctr_min(CTR_W));

    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != C_MAX) nxt = cur + 1'b1;
        end else if (cur != C_MIN) begin
            nxt = cur - 1'b1;
        end
    end
endmodule

// File: rtl/bp_table.sv
// Bimodal / gshare branch-direction table: one-cycle registered lookup,
// flop-based counter array, global history and misprediction counter.
module bp_table
    import bp_pkg::*;
#(
    parameter int CTR_W  = CTR_W_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int HIST_W = HIST_W_DEF,
    parameter int PC_W   = PC_W_DEF
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   pred_valid,
    input  logic [PC_W-1:0]                        pred_pc,
    output logic                                   pred_rdy,
    output logic                                   pred_taken,
    output logic [IDX_W-1:0]                       pred_idx,
    input  logic                                   upd_valid,
    input  logic [IDX_W-1:0]                       upd_idx,
    input  logic                                   upd_taken,
    input  logic                                   upd_pred,
    output logic [MIS_W-1:0]                       mispredict_cnt,
    output logic [((HIST_W > 0) ? HIST_W : 1)-1:0] ghr
);
    localparam int               NUM_ENT = 1 << IDX_W;
    localparam int               GHR_W   = (HIST_W > 0) ? HIST_W : 1;
    localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(ctr_rst_val(CTR_W));

    logic [NUM_ENT-1:0][CTR_W-1:0] w_tbl;
    logic [NUM_ENT-1:0][CTR_W-1:0] w_nxt;
    logic [IDX_W-1:0]              w_lk_idx;
    logic [IDX_W-1:0]              w_ghr_ext;
    logic [GHR_W-1:0]              w_ghr;
    logic [CTR_W-1:0]              w_rd_ctr;
    logic                          w_pc_unused;

    logic                          r_pred_rdy;
    logic                          r_pred_taken;
    logic [IDX_W-1:0]              r_pred_idx;
    logic [MIS_W-1:0]              r_mis;

    // Only the low IDX_W address bits take part in indexing.
    assign w_pc_unused = ^pred_pc;

    // History is read pre-shift, so a same-cycle update never affects the lookup.
    generate
        if (HIST_W > 0) begin : g_hist
            logic [GHR_W-1:0] r_ghr;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)         r_ghr <= '0;
                else if (upd_valid) r_ghr <= GHR_W'({r_ghr, upd_taken});
            end
            assign w_ghr     = r_ghr;
            assign w_ghr_ext = IDX_W'(r_ghr);
        end else begin : g_bimodal
            assign w_ghr     = '0;
            assign w_ghr_ext = '0;
        end
    endgenerate

    assign w_lk_idx = pred_pc[IDX_W-1:0] ^ w_ghr_ext;
    assign w_rd_ctr = w_tbl[w_lk_idx];

    generate
        for (genvar g = 0; g < NUM_ENT; g++) begin : g_ent
            logic [CTR_W-1:0] r_ctr;

            bp_sat_ctr #(.CTR_W(CTR_W)) u_ctr (
                .cur   (r_ctr),
                .taken (upd_taken),
                .nxt   (w_nxt[g])
            );

            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    r_ctr <= CTR_RST;
                else if (upd_valid && (upd_idx == IDX_W'(g)))
                    r_ctr <= w_nxt[g];
            end

            assign w_tbl[g] = r_ctr;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pred_rdy   <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_idx   <= '0;
        end else begin
            r_pred_rdy <= pred_valid;
            if (pred_valid) begin
                r_pred_taken <= w_rd_ctr[CTR_W-1];
                r_pred_idx   <= w_lk_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_mis <= '0;
        else if (upd_valid && (upd_taken != upd_pred) && (r_mis != MIS_SAT))
            r_mis <= r_mis + 16'd1;
    end

    assign pred_rdy       = r_pred_rdy;
    assign pred_taken     = r_pred_taken;
    assign pred_idx       = r_pred_idx;
    assign mispredict_cnt = r_mis;
    assign ghr            = w_ghr;
endmodule
